// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-type codes, FSM state type
// and byte-enable width. Imported by dmem_lane and dmem_resp.
package dmem_pkg;

  localparam int BE_W = 4;

  localparam logic [3:0] LS_BS = 4'b0001;
  localparam logic [3:0] LS_HS = 4'b0010;
  localparam logic [3:0] LS_W  = 4'b0100;
  localparam logic [3:0] LS_BU = 4'b1001;
  localparam logic [3:0] LS_HU = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic ls_legal(input logic [3:0] ls);
    return (ls inside {LS_BS, LS_HS, LS_W, LS_BU, LS_HU});
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: store byte enables and lane replication, and load
// byte/half extraction with sign or zero extension.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [3:0]      ls_i,
  input  logic [1:0]      off_i,
  input  logic [31:0]     wdata_i,
  input  logic [31:0]     rword_i,
  output logic [BE_W-1:0] be_o,
  output logic [31:0]     wlane_o,
  output logic [31:0]     rext_o,
  output logic            misal_o
);

  logic        is_b, is_h, is_w;
  logic [1:0]  aoff;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    is_b    = ls_i[0];
    is_h    = ls_i[1];
    is_w    = ls_i[2];
    misal_o = (is_h & off_i[0]) | (is_w & (|off_i));
    // Misaligned low bits are dropped; a trapping build faults before they matter.
    if (is_w)      aoff = 2'b00;
    else if (is_h) aoff = {off_i[1], 1'b0};
    else           aoff = off_i;

    be_o    = '0;
    wlane_o = {4{wdata_i[7:0]}};
    if (is_w) begin
      be_o    = 4'b1111;
      wlane_o = wdata_i;
    end else if (is_h) begin
      be_o    = 4'(4'b0011 << aoff);
      wlane_o = {2{wdata_i[15:0]}};
    end else if (is_b) begin
      be_o    = 4'(4'b0001 << aoff);
    end

    rbyte  = rword_i[{aoff, 3'b000} +: 8];
    rhalf  = aoff[1] ? rword_i[31:16] : rword_i[15:0];
    rext_o = '0;
    if (is_w)      rext_o = rword_i;
    else if (is_h) rext_o = ls_i[3] ? {16'h0000, rhalf} : {{16{rhalf[15]}}, rhalf};
    else if (is_b) rext_o = ls_i[3] ? {24'h000000, rbyte} : {{24{rbyte[7]}}, rbyte};
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-port data memory with request/ready handshake and programmable response latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYC    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  ls,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  ls_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [29:0]     widx;
  logic            oob;
  logic            fault;
  logic [31:0]     rword;
  logic [BE_W-1:0] be;
  logic [31:0]     wlane;
  logic [31:0]     rext;
  logic            misal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYC == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are frozen at acceptance so the requester may move on.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      ls_q    <= ls;
    end
  end

  assign widx  = addr_q[31:2];
  assign oob   = ({2'b00, widx} >= 32'(DEPTH_WORDS));
  assign rword = oob ? '0 : mem_q[widx[AW-1:0]];

  dmem_lane u_lane (
    .ls_i    (ls_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rword_i (rword),
    .be_o    (be),
    .wlane_o (wlane),
    .rext_o  (rext),
    .misal_o (misal)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = oob | ~ls_legal(ls_q) | misal;
`else
  logic unused_misal;
  assign unused_misal = misal;
  assign fault = oob | ~ls_legal(ls_q);
`endif

  assign ready = (state_q == RESP);
  assign err   = ready & fault;
  assign rdata = (ready && !fault && !we_q) ? rext : '0;

  // Stores commit on the edge that closes RESP; reset forces IDLE first, so an aborted access never writes.
  always_ff @(posedge clk) begin
    if (state_q == RESP && we_q && !fault) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem_q[widx[AW-1:0]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with WAIT_CYC=1 for data/fault/reset cases,
// one with WAIT_CYC=0 for back-to-back throughput.
module tb_dmem_resp;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req1, we1, ready1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  ls1;
  logic        req0, we0, ready0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  ls0;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        e;
  int          lat;

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ls(ls1), .rdata(rdata1), .ready(ready1), .err(err1)
  );

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ls(ls0), .rdata(rdata0), .ready(ready0), .err(err0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on dut1; inputs are scrambled after acceptance. l_o = edges from accept to ready.
  task automatic acc1(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] l, output logic [31:0] rd_o, output logic e_o,
                      output int l_o);
    @(negedge clk);
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; ls1 = l;
    @(posedge clk); #1;
    req1 = 1'b0; we1 = ~w; addr1 = 32'hFFFF_FFFC; wdata1 = 32'hFFFF_FFFF; ls1 = 4'b0011;
    l_o = -1; rd_o = 32'hXXXX_XXXX; e_o = 1'bx;
    for (int k = 0; k < 20; k++) begin
      if (ready1) begin
        l_o = k; rd_o = rdata1; e_o = err1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic rdy_seen, prev;
    int   pulses;
    logic consec;

    clk = 1'b0; rst = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; wdata1 = '0; ls1 = LS_W;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0;     wdata0 = '0; ls0 = LS_W;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  32'(ready1), 32'd0);
    chk("rst_err",    32'(err1),   32'd0);
    chk("rst_rdata",  rdata1,      32'd0);
    chk("rst_ready0", 32'(ready0), 32'd0);
    @(negedge clk);
    req1 = 1'b0; rst = 1'b1;

    acc1(1'b1, 32'h10, 32'hDEAD_BEEF, LS_W, rd, e, lat);
    chk("sw_lat",   32'(lat), 32'd1);
    chk("sw_err",   32'(e),   32'd0);
    chk("sw_rdata", rd,       32'd0);

    acc1(1'b0, 32'h10, 32'h0, LS_W, rd, e, lat);
    chk("lw_lat",   32'(lat), 32'd1);
    chk("lw_err",   32'(e),   32'd0);
    chk("lw_rdata", rd,       32'hDEAD_BEEF);

    acc1(1'b1, 32'h13, 32'hAAAA_AA80, LS_BS, rd, e, lat);
    chk("sb_err", 32'(e), 32'd0);
    acc1(1'b0, 32'h13, 32'h0, LS_BS, rd, e, lat);
    chk("lb_s", rd, 32'hFFFF_FF80);
    acc1(1'b0, 32'h13, 32'h0, LS_BU, rd, e, lat);
    chk("lb_u", rd, 32'h0000_0080);
    acc1(1'b0, 32'h10, 32'h0, LS_W, rd, e, lat);
    chk("lw_after_sb", rd, 32'h80AD_BEEF);
    acc1(1'b0, 32'h12, 32'h0, LS_HU, rd, e, lat);
    chk("lh_u_hi", rd, 32'h0000_80AD);

    acc1(1'b0, 32'h11, 32'h0, LS_HS, rd, e, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lh_mis_err",   32'(e), 32'd1);
    chk("lh_mis_rdata", rd,     32'd0);
`else
    chk("lh_mis_err",   32'(e), 32'd0);
    chk("lh_mis_rdata", rd,     32'hFFFF_BEEF);
`endif

    acc1(1'b1, 32'h10, 32'h5555_CAFE, LS_HU, rd, e, lat);
    chk("sh_err", 32'(e), 32'd0);
    acc1(1'b0, 32'h10, 32'h0, LS_W, rd, e, lat);
    chk("lw_after_sh", rd, 32'h80AD_CAFE);

    acc1(1'b0, 32'h0000_1000, 32'h0, LS_W, rd, e, lat);
    chk("oob_err",   32'(e), 32'd1);
    chk("oob_rdata", rd,     32'd0);
    acc1(1'b0, 32'h10, 32'h0, 4'b0011, rd, e, lat);
    chk("badls_err",   32'(e), 32'd1);
    chk("badls_rdata", rd,     32'd0);
    acc1(1'b1, 32'h10, 32'h0, 4'b0011, rd, e, lat);
    chk("badls_st_err", 32'(e), 32'd1);
    acc1(1'b1, 32'hFF0, 32'h1234_5678, LS_W, rd, e, lat);
    acc1(1'b1, 32'hFFFF_FFF0, 32'h0, LS_W, rd, e, lat);
    chk("wrap_err", 32'(e), 32'd1);
    acc1(1'b0, 32'hFF0, 32'h0, LS_W, rd, e, lat);
    chk("wrap_noalias", rd, 32'h1234_5678);
    acc1(1'b0, 32'h10, 32'h0, LS_W, rd, e, lat);
    chk("badls_nowrite", rd, 32'h80AD_CAFE);

    acc1(1'b1, 32'h20, 32'h1111_1111, LS_W, rd, e, lat);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h2222_2222; ls1 = LS_W;
    @(posedge clk); #1;
    req1 = 1'b0; rst = 1'b0;
    rdy_seen = ready1;
    repeat (3) begin
      @(posedge clk); #1;
      rdy_seen = rdy_seen | ready1;
    end
    chk("rst_mid_noready", 32'(rdy_seen), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    acc1(1'b0, 32'h20, 32'h0, LS_W, rd, e, lat);
    chk("rst_mid_nowrite", rd, 32'h1111_1111);

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0BAD_F00D; ls0 = LS_W;
    pulses = 0; consec = 1'b0; prev = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("b2b_ready", 32'(ready0), 32'(k % 2));
      if (ready0) pulses++;
      if (ready0 && prev) consec = 1'b1;
      prev = ready0;
    end
    @(negedge clk);
    req0 = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd5);
    chk("b2b_consec", 32'(consec), 32'd0);

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; ls0 = LS_W;
    @(posedge clk); #1;
    req0 = 1'b0;
    chk("w0_ready", 32'(ready0), 32'd1);
    chk("w0_rdata", rdata0,      32'h0BAD_F00D);
    chk("w0_err",   32'(err0),   32'd0);
    @(posedge clk); #1;
    chk("w0_ready_drop", 32'(ready0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the storage size in 32-bit words.
REQ-002 Parameter WAIT_CYC, default 1, range 0..15, SHALL set the extra cycles between request acceptance and response.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port req, input, 1, SHALL mark a valid access request; it is sampled only in IDLE.
REQ-006 Port we, input, 1, SHALL select store (1) or load (0); driven from the CPU MemWrite.
REQ-007 Port addr, input, 32, SHALL be the byte address; driven from the CPU ALU output.
REQ-008 Port wdata, input, 32, SHALL be the store data, right-aligned.
REQ-009 Port ls, input, 4, SHALL be the access type: 0001 byte signed, 0010 half signed, 0100 word, 1001 byte unsigned, 1010 half unsigned.
REQ-010 Port rdata, output, 32, SHALL be the extended load data, valid while ready=1.
REQ-011 Port ready, output, 1, SHALL be a one-cycle response strobe.
REQ-012 Port err, output, 1, SHALL flag a faulted access and is valid only with ready.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, and RESP.
- IDLE to WAIT on req=1 when WAIT_CYC>0.
- IDLE to RESP on req=1 when WAIT_CYC=0.
- WAIT to RESP when the counter reaches 0.
- RESP to IDLE unconditionally.
REQ-014 On acceptance, the block SHALL register we, addr, wdata, and ls; later input changes SHALL NOT affect the access in flight.
REQ-015 The wait counter SHALL load WAIT_CYC-1 on acceptance and decrement in WAIT; ready SHALL assert exactly WAIT_CYC+1 cycles after the accepting edge.
REQ-016 A store SHALL commit its byte lanes at the RESP edge, using a byte enable derived from ls[2:0] and addr[1:0]:
- byte: lane addr[1:0];
- half: lanes {addr[1],0} and {addr[1],1};
- word: all four lanes.
REQ-017 A load SHALL select the addressed byte or half of the word and then extend it:
- ls[3]=0: sign-extend;
- ls[3]=1: zero-extend;
- word: pass through unchanged.
REQ-018 For a store response, rdata SHALL be 0.
REQ-019 Word index addr[31:2] >= DEPTH_WORDS SHALL give err=1 and rdata=0, with no write.
REQ-020 An ls code outside REQ-009 SHALL give err=1, no write, and rdata=0.
REQ-021 ready and err SHALL be 0 in every state except RESP.
REQ-022 req in WAIT or RESP SHALL be ignored; no queuing; the requester holds req until it sees ready.
REQ-023 An address wrapping past the top word SHALL NOT alias; REQ-019 applies.

Reset
REQ-024 While rst=0, the block SHALL force state=IDLE, counter=0, ready=0, err=0, and rdata=0.
REQ-025 Reset mid-access SHALL abort the access with no memory write and no ready pulse.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With macro DMEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL respond with err=1, no write, and rdata=0. Misaligned means a half with addr[0]=1 or a word with addr[1:0]!=0.
REQ-028 Without DMEM_MISALIGN_TRAP_EN, the block SHALL force the misaligned low address bits to 0 and perform the access normally with err=0.

Structure
REQ-029 Package dmem_pkg SHALL hold:
- the ls encoding constants;
- the FSM state type;
- the byte-enable width constant.
REQ-030 Sub-module dmem_lane SHALL be the combinational load-extract and store byte-enable and lane-shift logic, instantiated once.

Verification
REQ-031 Reset, then with WAIT_CYC=1: store word 0xDEADBEEF to 0x10, then load word from 0x10. Required: the load returns rdata=0xDEADBEEF, ready on the second cycle after acceptance, err=0.
REQ-032 Store byte 0x80 to 0x13, then:
- load byte signed 0x13 returns 0xFFFFFF80;
- load byte unsigned 0x13 returns 0x00000080;
- load word 0x10 returns 0x80ADBEEF.
REQ-033 Load half from 0x11:
- with DMEM_MISALIGN_TRAP_EN: err=1, rdata=0;
- without it: the access reads 0x10 and returns 0xFFFFBEEF.
REQ-034 Load from 0x00001000 with DEPTH_WORDS=1024 returns err=1 and rdata=0; ls=0011 returns err=1.
REQ-035 Assert rst=0 while in WAIT of a store to 0x20, then read 0x20. Required: no ready pulse during reset, and the old contents of 0x20 are unchanged.
REQ-036 With WAIT_CYC=0, issue back-to-back requests holding req=1 through RESP. Required: one access is accepted every 2 cycles, with ready never on consecutive cycles.
